// File: rtl/evt_pkg.sv
// Shared defaults for the two-phase event-driven pipeline stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package evt_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : evt_pkg

// File: rtl/c_element_reg.sv
// Clocked 2-input Muller C-element: q follows the inputs when they agree, else holds.
// Latency: one clk edge from inputs agreeing to q updating.
// Backpressure: none of its own; the holding behaviour is what stalls the stage.
// Ports: clk, rst (async active-high), a, b (join inputs), q (registered state).
module c_element_reg (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (a == b) begin
            q <= a;
        end
    end

endmodule : c_element_reg

// File: rtl/evt_pipeline_stage.sv
// Two-phase bundled-data pipeline register: each C-element toggle captures data_in.
// Latency: Rout/data_out SYNC_STAGES edges after Rin is first sampled (1 edge if 0); Ain one edge later.
// Backpressure: a new Rin transition is only accepted once Aout has acknowledged the last Rout event.
// Ports: clk, rst (async active-high), data_in/Rin from upstream, Ain to upstream,
//        data_out/Rout to downstream, Aout from downstream.
module evt_pipeline_stage
    import evt_pkg::*;
#(
    parameter int width       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] data_in,
    input  logic             Rin,
    input  logic             Aout,
    output logic [width-1:0] data_out,
    output logic             Ain,
    output logic             Rout
);

    logic rin_s;
    logic aout_s;
    logic c;
    logic c_next;
    logic evt;
    logic ain_q;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign rin_s  = Rin;
            assign aout_s = Aout;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] rin_sync;
            logic [SYNC_STAGES-1:0] aout_sync;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rin_sync  <= '0;
                    aout_sync <= '0;
                end else begin
                    rin_sync[0]  <= Rin;
                    aout_sync[0] <= Aout;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        rin_sync[i]  <= rin_sync[i-1];
                        aout_sync[i] <= aout_sync[i-1];
                    end
                end
            end

            assign rin_s  = rin_sync[SYNC_STAGES-1];
            assign aout_s = aout_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Join the request with the inverted acknowledge: c can only move to the
    // new request phase once downstream has caught up with the previous one.
    c_element_reg u_c_element (
        .clk (clk),
        .rst (rst),
        .a   (rin_s),
        .b   (~aout_s),
        .q   (c)
    );

    // Mirror of the C-element's next state, used to fire the capture on the
    // very edge that c changes.
    assign c_next = (rin_s == ~aout_s) ? rin_s : c;
    assign evt    = (c_next != c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            ain_q    <= 1'b0;
        end else begin
            if (evt) begin
                data_out <= data_in;
            end
            // Upstream ack trails c by one edge so it never precedes the capture.
            ain_q <= c;
        end
    end

    assign Rout = c;
    assign Ain  = ain_q;

endmodule : evt_pipeline_stage

// File: tb/tb_evt_pipeline_stage.sv
module tb_evt_pipeline_stage;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       Rin;
    logic       Aout;
    logic [7:0] data_out;
    logic       Ain;
    logic       Rout;

    logic [7:0] d0_in;
    logic       r0_in;
    logic       a0_out;
    logic [7:0] d0_out;
    logic       a0_in;
    logic       r0_out;

    int checks;
    int errors;

    evt_pipeline_stage #(.width(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .Rin      (Rin),
        .Aout     (Aout),
        .data_out (data_out),
        .Ain      (Ain),
        .Rout     (Rout)
    );

    evt_pipeline_stage #(.width(8), .SYNC_STAGES(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (d0_in),
        .Rin      (r0_in),
        .Aout     (a0_out),
        .data_out (d0_out),
        .Ain      (a0_in),
        .Rout     (r0_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_sample;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; data_in = 8'h00; Rin = 1'b0; Aout = 1'b0;
        d0_in = 8'h00; r0_in = 1'b0; a0_out = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_out !== 8'h00 || Rout !== 1'b0 || Ain !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: data_out=%h Rout=%b Ain=%b, want 00 0 0", data_out, Rout, Ain);
        end
        rst = 1'b0;
        // Load 0xA5 with c=1, then hit reset between edges.
        @(negedge clk);
        data_in = 8'hA5; Rin = 1'b1;
        repeat (3) edge_sample();
        checks++;
        if (data_out !== 8'hA5 || Rout !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload: data_out=%h Rout=%b, want a5 1", data_out, Rout);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00 || Rout !== 1'b0 || Ain !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: data_out=%h Rout=%b Ain=%b, want 00 0 0", data_out, Rout, Ain);
        end
        Rin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single;
        @(negedge clk);
        data_in = 8'h3C; Rin = 1'b1;
        edge_sample();
        edge_sample();
        checks++;
        if (Rout !== 1'b0) begin
            errors++;
            $display("FAIL single_early: Rout=%b after 2 edges, want 0", Rout);
        end
        edge_sample();
        checks++;
        if (Rout !== 1'b1 || data_out !== 8'h3C || Ain !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: Rout=%b data_out=%h Ain=%b, want 1 3c 0", Rout, data_out, Ain);
        end
        edge_sample();
        checks++;
        if (Ain !== 1'b1) begin
            errors++;
            $display("FAIL single_ain: Ain=%b, want 1", Ain);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        data_in = 8'h55; Rin = 1'b0;
        repeat (6) edge_sample();
        checks++;
        if (Rout !== 1'b1 || data_out !== 8'h3C || Ain !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: Rout=%b data_out=%h Ain=%b, want 1 3c 1", Rout, data_out, Ain);
        end
        @(negedge clk);
        Aout = 1'b1;
        edge_sample();
        edge_sample();
        checks++;
        if (Rout !== 1'b1) begin
            errors++;
            $display("FAIL bp_early: Rout=%b, want 1", Rout);
        end
        edge_sample();
        checks++;
        if (Rout !== 1'b0 || data_out !== 8'h55) begin
            errors++;
            $display("FAIL bp_release: Rout=%b data_out=%h, want 0 55", Rout, data_out);
        end
        edge_sample();
        checks++;
        if (Ain !== 1'b0) begin
            errors++;
            $display("FAIL bp_ain: Ain=%b, want 0", Ain);
        end
    endtask

    task automatic test_streaming;
        logic       last_rout;
        logic [7:0] cap [16];
        int         idx;
        int         got;
        @(negedge clk);
        Aout = Rout;
        repeat (6) @(negedge clk);
        last_rout = Rout;
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 2000 && got < 16; cyc++) begin
            @(negedge clk);
            if (Rout !== last_rout) begin
                if (got < 16) cap[got] = data_out;
                got++;
                last_rout = Rout;
                Aout = Rout;
            end
            if (Ain === Rin && idx < 16) begin
                data_in = 8'(idx + 1);
                Rin = ~Rin;
                idx++;
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (got !== 16 || Rout !== last_rout) begin
            errors++;
            $display("FAIL stream_count: got=%0d extra_event=%b, want 16 0", got, Rout !== last_rout);
        end
        for (int i = 0; i < 16 && i < got; i++) begin
            checks++;
            if (cap[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL stream_item%0d: data_out=%h, want %h", i, cap[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_sync0;
        @(negedge clk);
        d0_in = 8'h9A; r0_in = 1'b1;
        edge_sample();
        checks++;
        if (r0_out !== 1'b1 || d0_out !== 8'h9A || a0_in !== 1'b0) begin
            errors++;
            $display("FAIL sync0_rout: Rout=%b data_out=%h Ain=%b, want 1 9a 0", r0_out, d0_out, a0_in);
        end
        edge_sample();
        checks++;
        if (a0_in !== 1'b1) begin
            errors++;
            $display("FAIL sync0_ain: Ain=%b, want 1", a0_in);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        data_in = 8'hE1; Rin = 1'b1;
        repeat (3) edge_sample();
        checks++;
        if (Rout !== 1'b1 || Ain !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_setup: Rout=%b Ain=%b, want 1 0", Rout, Ain);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (Rout !== 1'b0 || Ain !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_clear: Rout=%b Ain=%b data_out=%h, want 0 0 00", Rout, Ain, data_out);
        end
        Rin = 1'b0; Aout = 1'b0; r0_in = 1'b0; a0_out = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) edge_sample();
        checks++;
        if (Rout !== 1'b0 || Ain !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_idle: Rout=%b Ain=%b data_out=%h, want 0 0 00", Rout, Ain, data_out);
        end
        @(negedge clk);
        data_in = 8'h77; Rin = 1'b1;
        repeat (3) edge_sample();
        checks++;
        if (Rout !== 1'b1 || data_out !== 8'h77) begin
            errors++;
            $display("FAIL rstmid_xfer: Rout=%b data_out=%h, want 1 77", Rout, data_out);
        end
        edge_sample();
        checks++;
        if (Ain !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ain: Ain=%b, want 1", Ain);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_sync0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_evt_pipeline_stage
